updown_sweep_ctrl: RTL and testbench
====================================

UPDOWN_SWEEP_CTRL -- requirements
Module: updown_sweep_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the count width.
REQ-002 SHALL have input clk, 1 bit: the single clock; all state changes on rising edge.
REQ-003 SHALL have input reset, 1 bit: asynchronous, active-high.
REQ-004 SHALL have input start, 1 bit: requests a sweep job; sampled only in IDLE.
REQ-005 SHALL have input abort, 1 bit: terminates an active job.
REQ-006 SHALL have input hold, 1 bit: freezes count and state while high in UP/DOWN.
REQ-007 SHALL have input lo, WIDTH bits: lower sweep bound, latched at start.
REQ-008 SHALL have input hi, WIDTH bits: upper sweep bound, latched at start.
REQ-009 SHALL have input sweeps, WIDTH bits: number of full lo->hi->lo periods, latched at start.
REQ-010 SHALL have output count, WIDTH bits: registered counter value.
REQ-011 SHALL have output upordown, 1 bit: 1 while counting up (UP state), else 0.
REQ-012 SHALL have output busy, 1 bit: high in UP and DOWN.
REQ-013 SHALL have output done, 1 bit: one-cycle pulse on normal job completion.
REQ-014 SHALL have output err, 1 bit: one-cycle pulse on a rejected start.

Function
REQ-015 SHALL implement states IDLE, UP, DOWN, DONE.
REQ-016 In IDLE, start=1 with lo<hi and sweeps!=0 SHALL latch lo/hi/sweeps, load count<=lo, and go to UP on the same edge.
REQ-017 In IDLE, start=1 with lo>=hi or sweeps==0 SHALL pulse err for one cycle, stay in IDLE, and leave count unchanged.
REQ-018 In UP: if count!=hi, count<=count+1; if count==hi, count<=count-1 and go to DOWN.
REQ-019 In DOWN with count!=lo, count SHALL become count-1.
REQ-020 In DOWN with count==lo and remaining>1, the block SHALL decrement remaining, set count<=count+1, and go to UP.
REQ-021 In DOWN with count==lo and remaining==1, the block SHALL hold count and go to DONE.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE; count holds lo.
REQ-023 Timing: with start sampled at edge 0, done SHALL be high in the cycle after edge 2*N*(hi-lo)+1.
REQ-024 hold=1 in UP/DOWN SHALL freeze count, state and remaining.
REQ-025 abort=1 in UP/DOWN SHALL return to IDLE on the next edge, freeze count, and never pulse done; abort has priority over hold.
REQ-026 start in UP/DOWN/DONE SHALL be ignored; abort and hold in IDLE/DONE SHALL be ignored.
REQ-027 count SHALL never leave [lo,hi] during a job, and no wrap-around is permitted.
REQ-028 Changes on lo/hi/sweeps during a job SHALL have no effect.

Reset
REQ-029 reset=1 SHALL immediately force IDLE, with count=0, upordown=0, busy=0, done=0, err=0 and remaining=0, regardless of the clock.
REQ-030 Reset mid-job SHALL discard the job; the first start after reset deassertion SHALL be honoured normally.

Structure
REQ-031 Package updown_sweep_pkg SHALL hold the state encoding constants (IDLE, UP, DOWN, DONE) and the default WIDTH.
REQ-032 The counter register SHALL be one sub-module, sweep_counter_core, with inputs en, dir and load/load_val and output count; the FSM and remaining counter stay in the top module.
REQ-033 All outputs SHALL be registered or decoded directly from state registers, with no input-to-output combinational path.

Verification
REQ-034 lo=2, hi=5, sweeps=2, start pulse -> count 2,3,4,5,4,3,2,3,4,5,4,3,2, hold 2; done high after edge 13; busy low afterwards.
REQ-035 lo=5, hi=5, start -> err pulse for 1 cycle; busy stays 0; count unchanged.
REQ-036 lo=0, hi=15, sweeps=1, with hold high for 3 cycles at count=7 -> count stays 7 for 3 cycles; done arrives 3 cycles later than the 31-edge nominal.
REQ-037 Abort at count=4 while in UP -> IDLE on the next edge; count=4 held; no done pulse; a new start is then accepted.
REQ-038 Reset asserted mid-DOWN between clock edges -> all outputs zero immediately; start after release gives a normal job.
REQ-039 start held high throughout a job -> no restart while busy; after DONE, a new job begins on the first IDLE cycle.

Source files
------------

// File: rtl/updown_sweep_pkg.sv
// Shared definitions for the up/down sweep controller: default count width
// and the controller state encoding.
package updown_sweep_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sweep_counter_core.sv
// Loadable up/down counter register used by the sweep controller.
// Ports: clk, reset (async, active-high), en (step enable), dir (1=up, 0=down),
//        load/load_val (synchronous load, priority over en), count (register).
module sweep_counter_core
    import updown_sweep_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);

    // Load wins over stepping; the controller never steps past its bounds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= WIDTH'(0);
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= dir ? (count + WIDTH'(1)) : (count - WIDTH'(1));
        end
    end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Up/down sweep controller: on an accepted start, counts lo->hi->lo for the
// requested number of periods, then pulses done. Supports hold and abort.
// Ports: clk, reset (async, active-high), start, abort, hold, lo, hi, sweeps
//        (job parameters, latched at start); count (counter register),
//        upordown (UP state), busy (UP or DOWN), done (DONE state pulse),
//        err (registered pulse on a rejected start).
module updown_sweep_ctrl
    import updown_sweep_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] sweeps,
    output logic [WIDTH-1:0] count,
    output logic             upordown,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             err_q, err_d;

    logic             cnt_en;
    logic             cnt_dir;
    logic             cnt_load;

    sweep_counter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .en      (cnt_en),
        .dir     (cnt_dir),
        .load    (cnt_load),
        .load_val(lo),
        .count   (count)
    );

    // State, remaining-period count, latched bounds and error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= WIDTH'(0);
            lo_q    <= WIDTH'(0);
            hi_q    <= WIDTH'(0);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
        end
    end

    // Next-state and counter control; abort outranks hold in UP/DOWN.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        err_d    = 1'b0;
        cnt_en   = 1'b0;
        cnt_dir  = 1'b0;
        cnt_load = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if ((lo < hi) && (sweeps != WIDTH'(0))) begin
                        lo_d     = lo;
                        hi_d     = hi;
                        rem_d    = sweeps;
                        cnt_load = 1'b1;
                        state_d  = UP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            UP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!hold) begin
                    cnt_en = 1'b1;
                    if (count == hi_q) begin
                        cnt_dir = 1'b0;
                        state_d = DOWN;
                    end else begin
                        cnt_dir = 1'b1;
                    end
                end
            end
            DOWN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!hold) begin
                    if (count != lo_q) begin
                        cnt_en  = 1'b1;
                        cnt_dir = 1'b0;
                    end else if (rem_q != WIDTH'(1)) begin
                        // Another period remains: turn around at lo.
                        rem_d   = rem_q - WIDTH'(1);
                        cnt_en  = 1'b1;
                        cnt_dir = 1'b1;
                        state_d = UP;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode straight from registers.
    assign upordown = (state_q == UP);
    assign busy     = (state_q == UP) || (state_q == DOWN);
    assign done     = (state_q == DONE);
    assign err      = err_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Self-checking bench for updown_sweep_ctrl: a trajectory-based model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_updown_sweep_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       hold;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] sweeps;
    logic [3:0] count;
    logic       upordown;
    logic       busy;
    logic       done;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    updown_sweep_ctrl #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .hold    (hold),
        .lo      (lo),
        .hi      (hi),
        .sweeps  (sweeps),
        .count   (count),
        .upordown(upordown),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted job is the full list of count values it will show,
    // one per unheld edge; done follows the last entry.
    int  traj[$];
    int  pos     = 0;
    bit  m_act   = 1'b0;
    bit  m_done  = 1'b0;
    bit  m_err   = 1'b0;
    int  m_count = 0;

    task automatic model_reset();
        traj.delete();
        pos     = 0;
        m_act   = 1'b0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_count = 0;
    endtask

    task automatic model_edge();
        m_err = 1'b0;
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_act) begin
            if (abort) begin
                m_act = 1'b0;
            end else if (!hold) begin
                if (pos == traj.size() - 1) begin
                    m_act  = 1'b0;
                    m_done = 1'b1;
                end else begin
                    pos++;
                    m_count = traj[pos];
                end
            end
        end else if (start) begin
            if ((int'(lo) < int'(hi)) && (sweeps != 4'd0)) begin
                traj.delete();
                for (int s = 0; s < int'(sweeps); s++) begin
                    for (int v = int'(lo); v < int'(hi); v++) traj.push_back(v);
                    for (int v = int'(hi); v > int'(lo); v--) traj.push_back(v);
                end
                traj.push_back(int'(lo));
                pos     = 0;
                m_act   = 1'b1;
                m_count = traj[0];
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_edge();
    end

    function automatic bit m_up();
        if (!m_act) return 1'b0;
        if (pos == 0) return 1'b1;
        return traj[pos] > traj[pos-1];
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_count",    int'(count),    m_count);
            chk("model_upordown", int'(upordown), int'(m_up()));
            chk("model_busy",     int'(busy),     int'(m_act));
            chk("model_done",     int'(done),     int'(m_done));
            chk("model_err",      int'(err),      int'(m_err));
        end
    end

    task automatic launch(input int l, input int h, input int n, input bit keep);
        @(negedge clk);
        lo     = 4'(l);
        hi     = 4'(h);
        sweeps = 4'(n);
        start  = 1'b1;
        @(negedge clk);
        if (!keep) start = 1'b0;
    endtask

    task automatic wait_done(input int exp, input string nm);
        int idx;
        idx = -1;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                idx = i;
                break;
            end
            @(negedge clk);
        end
        chk(nm, idx, exp);
    endtask

    int exp_seq[14] = '{2, 3, 4, 5, 4, 3, 2, 3, 4, 5, 4, 3, 2, 2};

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        hold   = 1'b0;
        lo     = 4'd0;
        hi     = 4'd0;
        sweeps = 4'd0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_busy",  int'(busy),  0);
        chk("rst_done",  int'(done),  0);
        reset = 1'b0;

        // Two periods 2..5, bounds changed mid-job must not matter.
        launch(2, 5, 2, 1'b0);
        chk("traj_len", traj.size(), 13);
        for (int i = 0; i < 14; i++) begin
            if (i == 5) begin
                lo     = 4'd0;
                hi     = 4'd15;
                sweeps = 4'd7;
            end
            chk($sformatf("seq_count[%0d]", i), int'(count), exp_seq[i]);
            chk($sformatf("seq_done[%0d]", i),  int'(done),  (i == 13) ? 1 : 0);
            @(negedge clk);
        end
        chk("seq_busy_after", int'(busy), 0);
        chk("seq_done_after", int'(done), 0);

        // Rejected start: lo == hi.
        launch(5, 5, 1, 1'b0);
        chk("rej_err",   int'(err),   1);
        chk("rej_busy",  int'(busy),  0);
        chk("rej_count", int'(count), 2);
        @(negedge clk);
        chk("rej_err_clear", int'(err), 0);
        launch(3, 6, 0, 1'b0);
        chk("rej_zero_sweeps", int'(err), 1);

        // Full range with a 3-cycle hold at count 7.
        launch(0, 15, 1, 1'b0);
        begin
            bit held;
            int hcnt;
            int idx;
            held = 1'b0;
            hcnt = 0;
            idx  = -1;
            for (int i = 0; i < 60; i++) begin
                if (done) begin
                    idx = i;
                    break;
                end
                if (hold) begin
                    hcnt++;
                    chk("hold_count", int'(count), 7);
                    if (hcnt == 3) hold = 1'b0;
                end else if (!held && count == 4'd7) begin
                    held = 1'b1;
                    hold = 1'b1;
                end
                @(negedge clk);
            end
            chk("hold_done_idx", idx, 34);
        end
        @(negedge clk);

        // Abort at count 4 while counting up, then a fresh job.
        launch(1, 6, 1, 1'b0);
        repeat (3) @(negedge clk);
        chk("abort_pre_count", int'(count), 4);
        abort = 1'b1;
        hold  = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        hold  = 1'b0;
        chk("abort_busy",  int'(busy),  0);
        chk("abort_count", int'(count), 4);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", int'(done), 0);
        end
        launch(0, 2, 1, 1'b0);
        wait_done(5, "after_abort_done_idx");
        @(negedge clk);

        // Asynchronous reset in the middle of a DOWN run.
        launch(3, 6, 2, 1'b0);
        repeat (4) @(negedge clk);
        chk("pre_rst_count", int'(count),    5);
        chk("pre_rst_up",    int'(upordown), 0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_count", int'(count),    0);
        chk("async_rst_busy",  int'(busy),     0);
        chk("async_rst_up",    int'(upordown), 0);
        @(negedge clk);
        reset = 1'b0;
        // hold and abort in IDLE have no effect.
        abort = 1'b1;
        hold  = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        hold  = 1'b0;
        launch(1, 3, 1, 1'b0);
        wait_done(5, "after_rst_done_idx");
        @(negedge clk);

        // start held high: no restart while busy, restart from IDLE.
        launch(0, 1, 1, 1'b1);
        wait_done(3, "held_start_done_idx");
        @(negedge clk);
        chk("held_start_idle", int'(busy), 0);
        @(negedge clk);
        chk("held_start_restart", int'(busy), 1);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("final_idle", int'(busy), 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
